// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between the MEM-stage control decoder
//               (master) and the data-memory responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface dmem_responder_if;
  logic        en_dmem;
  logic        load_store;
  logic [2:0]  funct3_dmem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output en_dmem, load_store, funct3_dmem, addr, wdata,
    input  busy, done, rdata, err
  );

  modport slave (
    input  en_dmem, load_store, funct3_dmem, addr, wdata,
    output busy, done, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-organised data RAM with byte-lane stores, sign/zero
//               extended loads and a two-state IDLE/RESP handshake. Misaligned,
//               illegal-funct3 and out-of-range requests complete with err.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic        w_accept;
  logic [AW-1:0] w_idx;
  logic [1:0]  w_lane;
  logic [1:0]  w_size;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_oor;
  logic        w_reject;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  logic        r_err;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_word;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Request decode; only meaningful in IDLE while en_dmem is high.
  assign w_accept   = (r_state == IDLE) && bus.en_dmem;
  assign w_idx      = bus.addr[AW+1:2];
  assign w_lane     = bus.addr[1:0];
  assign w_size     = bus.funct3_dmem[1:0];
  // Loads reject 011/110/111, stores reject everything above 010.
  assign w_illegal  = bus.load_store
                      ? (bus.funct3_dmem[2] || (w_size == 2'b11))
                      : ((w_size == 2'b11) || (bus.funct3_dmem[2] && (w_size == 2'b10)));
  assign w_misalign = ((w_size == 2'b01) && w_lane[0]) ||
                      ((w_size == 2'b10) && (w_lane != 2'b00));
  assign w_oor      = |bus.addr[31:AW+2];
  assign w_reject   = w_illegal || w_misalign || w_oor;
  // Writes are suppressed while reset is asserted so a held store cannot land.
  assign w_we       = w_accept && rst_n && bus.load_store && !w_reject;

  // Byte enables and lane-replicated store data for SB/SH/SW.
  always_comb begin
    w_be = 4'b1111;
    w_wd = bus.wdata;
    case (w_size)
      2'b00: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{bus.wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = bus.wdata;
      end
    endcase
  end

  // RAM: byte-lane write and word capture at the accepting edge; never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem[w_idx][b*8 +: 8] <= w_wd[b*8 +: 8];
      end
    end
    if (w_accept) r_word <= mem[w_idx];
  end

  // State register and per-request attributes captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_err     <= 1'b0;
      r_is_load <= 1'b0;
      r_funct3  <= 3'b000;
      r_lane    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_err     <= w_reject;
        r_is_load <= !bus.load_store;
        r_funct3  <= bus.funct3_dmem;
        r_lane    <= w_lane;
      end
    end
  end

  // Lane selection and extension of the captured word.
  always_comb begin
    case (r_lane)
      2'b00:   w_byte = r_word[7:0];
      2'b01:   w_byte = r_word[15:8];
      2'b10:   w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
    w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = r_word;
    endcase
  end

  // Next state and outputs; all outputs follow the async-reset state register.
  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.err     = 1'b0;
    bus.rdata   = 32'h0;
    case (r_state)
      IDLE: begin
        if (bus.en_dmem) w_state_nxt = RESP;
      end
      RESP: begin
        w_state_nxt = IDLE;
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.err     = r_err;
        if (r_is_load && !r_err) bus.rdata = w_load_data;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
